// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO between the CPU write path and the UART transmitter.
// Reports occupancy and a sticky overflow flag for dropped writes.
module uart_tx_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     enq_data,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  output logic [WIDTH-1:0]     deq_data,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic [PTR_WIDTH:0]   count,
  output logic                 overflow
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 enq_fire;
  logic                 deq_fire;

  // Handshakes depend only on registered occupancy, so there is no
  // combinational path from deq_ready to enq_ready.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  assign deq_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + (PTR_WIDTH+1)'(1);
        2'b01:   count <= count - (PTR_WIDTH+1)'(1);
        default: count <= count;
      endcase
      // A write offered while full is dropped; remember it until reset.
      if (enq_valid && !enq_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued and checked as they leave.
module tb_uart_tx_fifo;

  localparam int FRAME = 2865;  // 10 bit times at 33 MHz / 115200 baud

  logic       clk;
  logic       reset;
  logic [7:0] enq_data;
  logic       enq_valid;
  logic       enq_ready;
  logic [7:0] deq_data;
  logic       deq_valid;
  logic       deq_ready;
  logic [3:0] count;
  logic       overflow;

  int         checks;
  int         errors;
  int         rx_cnt;
  bit         mon_en;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .enq_data(enq_data), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .deq_data(deq_data), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: inputs are stable at the falling edge, so any
  // handshake seen here fires at the following rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        exp_q.delete();
      end else begin
        checks++;
        if (count !== 4'(exp_q.size())) begin
          errors++;
          $display("FAIL mon_count: got %0d, want %0d", count, exp_q.size());
        end
        checks++;
        if (enq_ready !== (exp_q.size() < 8)) begin
          errors++;
          $display("FAIL mon_enq_ready: got %b, want %b", enq_ready, exp_q.size() < 8);
        end
        checks++;
        if (deq_valid !== (exp_q.size() != 0)) begin
          errors++;
          $display("FAIL mon_deq_valid: got %b, want %b", deq_valid, exp_q.size() != 0);
        end
        if (deq_valid && deq_ready && exp_q.size() != 0) begin
          logic [7:0] exp;
          exp = exp_q.pop_front();
          checks++;
          rx_cnt++;
          if (deq_data !== exp) begin
            errors++;
            $display("FAIL mon_deq_data: got %02h, want %02h", deq_data, exp);
          end
        end
        if (enq_valid && enq_ready) exp_q.push_back(enq_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      enq_valid = 1'b1;
      enq_data  = base + 8'(i);
      tick();
    end
    enq_valid = 1'b0;
  endtask

  task automatic drain();
    deq_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    deq_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b, want 1", enq_ready); end
    checks++;
    if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b, want 0", deq_valid); end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d, want 0", count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, want 0", overflow); end
    mon_en = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      enq_valid = 1'b1;
      enq_data  = 8'h41 + 8'(i);
      tick();
      checks++;
      if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d, want %0d", count, i + 1); end
    end
    enq_valid = 1'b0;
    checks++;
    if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_enq_ready: got %b, want 0", enq_ready); end
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (deq_valid !== 1'b1 || deq_data !== 8'h41 + 8'(i)) begin
        errors++;
        $display("FAIL drain_data: got %b/%02h, want 1/%02h", deq_valid, deq_data, 8'h41 + 8'(i));
      end
      tick();
    end
    checks++;
    if (count !== 4'd0 || deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got count=%0d valid=%b, want 0/0", count, deq_valid);
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_overflow();
    fill(8'h50, 8);
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL ovf_prefill: got %0d, want 8", count); end
    enq_valid = 1'b1;
    enq_data  = 8'h99;
    tick();
    enq_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b count=%0d, want 1/8", overflow, count);
    end
    tick();
    tick();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, want 1", overflow); end
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (deq_valid) begin
        checks++;
        if (deq_data === 8'h99) begin errors++; $display("FAIL ovf_dropped: got 99, want not 99"); end
      end
      tick();
    end
    deq_ready = 1'b0;
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, want 0", overflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    d = 8'h00;
    fill(d, 3);
    d = 8'h03;
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_data = d;
      d++;
      tick();
      checks++;
      if (count !== 4'd3) begin errors++; $display("FAIL simul_count3: got %0d, want 3", count); end
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    fill(d, 5);
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL simul_full: got %0d, want 8", count); end
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    enq_data  = 8'hEE;
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    checks++;
    if (count !== 4'd7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL simul_full_refuse: got count=%0d ovf=%b, want 7/1", count, overflow);
    end
    drain();
    do_reset();
  endtask

  task automatic test_wrap();
    int  sent;
    int  start;
    bit  acc;
    sent  = 0;
    start = rx_cnt;
    for (int cyc = 0; cyc < 3000 && (rx_cnt - start) < 100; cyc++) begin
      enq_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      enq_data  = 8'(sent);
      deq_ready = ($urandom_range(0, 2) != 0);
      acc = enq_valid && enq_ready;
      tick();
      if (acc) sent++;
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    checks++;
    if ((rx_cnt - start) != 100 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_total: got %0d out, %0d left, want 100 out, 0 left", rx_cnt - start, exp_q.size());
    end
  endtask

  task automatic test_tx_stream();
    logic [7:0] cap [4];
    int         cap_cyc [4];
    int         ncap;
    int         busy;
    bit         did_rst;
    ncap    = 0;
    busy    = 0;
    did_rst = 1'b0;
    enq_valid = 1'b1;
    enq_data = 8'h48; tick();
    enq_data = 8'h69; tick();
    enq_data = 8'h21; tick();
    enq_valid = 1'b0;
    for (int cyc = 0; cyc < 3 * FRAME; cyc++) begin
      if (ncap == 2 && busy == FRAME / 2 && !did_rst) begin
        deq_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        did_rst   = 1'b1;
        checks++;
        if (count !== 4'd0 || deq_valid !== 1'b0) begin
          errors++;
          $display("FAIL tx_reset_empty: got count=%0d valid=%b, want 0/0", count, deq_valid);
        end
      end else begin
        deq_ready = (busy == 0);
        if (deq_ready && deq_valid) begin
          if (ncap < 4) begin
            cap[ncap]     = deq_data;
            cap_cyc[ncap] = cyc;
          end
          ncap++;
          busy = FRAME;
        end
        tick();
      end
      if (busy > 0) busy--;
    end
    deq_ready = 1'b0;
    checks++;
    if (ncap != 2) begin errors++; $display("FAIL tx_frames: got %0d, want 2", ncap); end
    if (ncap >= 2) begin
      checks++;
      if (cap[0] !== 8'h48 || cap[1] !== 8'h69) begin
        errors++;
        $display("FAIL tx_bytes: got %02h %02h, want 48 69", cap[0], cap[1]);
      end
      checks++;
      if (cap_cyc[1] - cap_cyc[0] != FRAME) begin
        errors++;
        $display("FAIL tx_back_to_back: got gap %0d, want %0d", cap_cyc[1] - cap_cyc[0], FRAME);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rx_cnt    = 0;
    mon_en    = 1'b0;
    reset     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = 8'h00;
    deq_ready = 1'b0;
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_tx_stream();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
